mandel_pixel_drain: RTL and testbench
=====================================

# mandel_pixel_drain

Per-pixel sequencer and output buffer that sits directly downstream of the `mandelbrot` iteration core. It issues one-cycle `run` pulses to start each pixel and detects pixel completion from `running`. It captures the 4-bit `ctr_out` into a small FIFO, tagged with start-of-frame, end-of-line and end-of-frame flags. A valid/ready stream presents the pixels to the video/pin interface. It throttles the core so no pixel is lost when the consumer stalls.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `WIDTH`, 320, pixels per line; must match the core
- `HEIGHT`, 240, lines per frame; must match the core
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high; clock clk
- `enable`  in  1  level; permits issuing new pixels
- `run`  out  1  to core `run`; one-cycle start pulse
- `running`  in  1  from core `running`
- `ctr_in`  in  4  from core `ctr_out`
- `finished`  in  1  from core `finished`
- `out_data`  out  4  pixel iteration value
- `out_sof`  out  1  entry is pixel (0,0)
- `out_eol`  out  1  entry is pixel x=WIDTH-1
- `out_eof`  out  1  entry is pixel (WIDTH-1, HEIGHT-1)
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts the head entry when high with `out_valid`
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- FSM states:
  - IDLE, ISSUE, BUSY.
  - IDLE -> ISSUE when `enable` && `running`==0 && `level`<DEPTH.
  - ISSUE -> BUSY unconditionally.
  - BUSY -> IDLE when `running`==0.
- ISSUE: `run`=1 for exactly that cycle; `run`=0 in all other states.
- Frame resync in ISSUE: if `finished`==1, the internal x/y counters load 0. The core restarts its frame on this `run`.
- Completion and push:
  - Completion is BUSY with `running`==0.
  - That cycle, push {`ctr_in`, sof=(x==0&&y==0), eol=(x==WIDTH-1), eof=(eol&&y==HEIGHT-1)}.
  - Then advance x; at WIDTH-1, x wraps to 0 and y increments; at (WIDTH-1, HEIGHT-1), both wrap to 0.
- Overflow avoidance:
  - At most one pixel is in flight.
  - A pixel is issued only with `level`<DEPTH, and pops only lower `level`.
  - Therefore a push never meets a full FIFO; no overflow path exists.
- FIFO:
  - First-word fall-through; the head entry drives the out_* data/flags.
  - Pop when `out_valid`&&`out_ready`.
  - Simultaneous push and pop leaves `level` unchanged and keeps order.
  - Pop when empty is ignored.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- Stalls:
  - `out_data`/flags stay stable while `out_valid`&&!`out_ready`.
  - Deasserting `enable` in BUSY lets the current pixel complete and push, then holds in IDLE.
- Frames run back-to-back while `enable` is high; the x/y counters carry the frame position across frames.

## Timing
- Reset values:
  - FSM=IDLE, `run`=0, FIFO empty.
  - `level`=0, `out_valid`=0, `out_data`=0, all out flags 0, x=y=0.
- Reset overrides every other input in the same cycle.
- Reset mid-BUSY discards the in-flight pixel; the core is reset on the same line.
- Issue latency: `enable` rising in IDLE with space gives `run` high on the next cycle.
- Core handshake: the cycle after `run`, the core drives `running`=1. BUSY must not sample completion before `running` has been seen high.
- Completion: `ctr_in` is valid in the first cycle `running` reads 0. It is captured that cycle.
- Push to `out_valid` latency: 1 cycle (registered occupancy).
- Next issue after completion: BUSY -> IDLE -> ISSUE, so ≥2 cycles from completion to next `run`.
- Per-pixel overhead beyond core iteration time: 3 cycles.

## Test plan
- **Reset:** hold `reset` 2 cycles with `enable`=1 → `run`=0, `out_valid`=0, `level`=0 during reset. First `run` pulse 1 cycle after release.
- **Single pixel:** core model completes 5 cycles after `run` with `ctr_in`=4'hA → one entry: `out_data`=A, `out_sof`=1, `out_eol`=0; `out_valid` rises 1 cycle after completion.
- **Line/frame tags:** WIDTH=4, HEIGHT=2, `out_ready`=1, 8 pixels → eol on pixels 3 and 7, eof only on pixel 7, sof on pixel 0. A 9th pixel issued with `finished`=1 carries sof=1.
- **Backpressure:** DEPTH=4, `out_ready`=0 → exactly 4 `run` pulses, `level`=4, no 5th `run`. Raise `out_ready` for 1 cycle → `level`=3, 5th `run` follows, data order preserved.
- **Simultaneous push/pop:** `level`=2, push and pop on the same cycle → `level` stays 2; head advances to the next entry.
- **Enable/reset mid-pixel:** drop `enable` in BUSY → the pixel is still pushed, no further `run`. Assert `reset` in BUSY → no push, `level`=0, FSM back to IDLE.

Source files
------------

// File: rtl/mandel_pixel_drain.sv
// Pixel sequencer and output FIFO downstream of the mandelbrot core.
// Starts one pixel at a time, tags each result with frame position, and streams it out.
module mandel_pixel_drain #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  output logic                       run,
  input  logic                       running,
  input  logic [3:0]                 ctr_in,
  input  logic                       finished,
  output logic [3:0]                 out_data,
  output logic                       out_sof,
  output logic                       out_eol,
  output logic                       out_eof,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef struct packed {
    logic [3:0] data;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_t;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t         state;
  logic           seen;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  pix_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  level_next;
  logic           push;
  logic           pop;
  logic           x_last;
  logic           y_last;

  assign x_last = (x == XW'(WIDTH - 1));
  assign y_last = (y == YW'(HEIGHT - 1));
  // Completion only counts once the core has acknowledged the run pulse.
  assign push   = (state == BUSY) && seen && !running;
  assign pop    = out_valid && out_ready;

  // Sequencer: at most one pixel in flight, issued only when the FIFO has room.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      run   <= 1'b0;
      seen  <= 1'b0;
      x     <= '0;
      y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          run <= 1'b0;
          if (enable && !running && (level < LW'(DEPTH))) begin
            state <= ISSUE;
            run   <= 1'b1;
          end
        end
        ISSUE: begin
          run   <= 1'b0;
          seen  <= 1'b0;
          state <= BUSY;
          if (finished) begin
            x <= '0;
            y <= '0;
          end
        end
        BUSY: begin
          run <= 1'b0;
          if (running) begin
            seen <= 1'b1;
          end else if (seen) begin
            state <= IDLE;
            if (x_last) begin
              x <= '0;
              y <= y_last ? '0 : y + YW'(1);
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          run   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    level_next = level;
    if (push && !pop)
      level_next = level + LW'(1);
    else if (!push && pop)
      level_next = level - LW'(1);
  end

  // First-word fall-through storage; occupancy and valid are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{data: ctr_in,
                         sof:  (x == '0) && (y == '0),
                         eol:  x_last,
                         eof:  x_last && y_last};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      level     <= level_next;
      out_valid <= (level_next != '0);
    end
  end

  assign out_data = mem[rd_ptr].data;
  assign out_sof  = mem[rd_ptr].sof;
  assign out_eol  = mem[rd_ptr].eol;
  assign out_eof  = mem[rd_ptr].eof;

endmodule

// File: tb/tb_mandel_pixel_drain.sv
// Bench for mandel_pixel_drain: behavioural core model feeding a scoreboard of tagged pixels.
module tb_mandel_pixel_drain;

  localparam int DEPTH = 4;
  localparam int W     = 4;
  localparam int H     = 2;
  localparam int NPIX  = W * H;
  localparam int LAT   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       run;
  logic       core_running = 1'b0;
  logic [3:0] ctr_in = 4'h0;
  logic       finished = 1'b0;
  logic [3:0] out_data;
  logic       out_sof, out_eol, out_eof, out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] level;

  int n_cmp = 0;
  int n_bad = 0;

  mandel_pixel_drain #(.DEPTH(DEPTH), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .enable(enable), .run(run), .running(core_running),
    .ctr_in(ctr_in), .finished(finished), .out_data(out_data), .out_sof(out_sof),
    .out_eol(out_eol), .out_eof(out_eof), .out_valid(out_valid), .out_ready(out_ready),
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected entry {data, sof, eol, eof} for frame position idx.
  function automatic logic [6:0] exp_of(input int idx, input logic [3:0] v);
    logic e;
    e = ((idx % W) == W - 1);
    return {v, idx == 0, e, idx == NPIX - 1};
  endfunction

  logic [6:0] sb [$];
  logic [6:0] pend = '0;
  logic [3:0] val = 4'hA;
  int         p = 0;
  int         core_cnt = 0;
  int         run_cnt = 0;
  logic       done_pulse = 1'b0;

  // Core model: running rises after run, stays LAT cycles, result valid as it falls.
  always @(posedge clk) begin
    if (reset) begin
      core_running <= 1'b0;
      core_cnt     <= 0;
      done_pulse   <= 1'b0;
      p            <= 0;
      sb.delete();
    end else begin
      done_pulse <= 1'b0;
      if (run) begin
        run_cnt      <= run_cnt + 1;
        core_running <= 1'b1;
        core_cnt     <= LAT;
        pend         <= exp_of(finished ? 0 : p, val);
        p            <= finished ? 1 : (p + 1) % NPIX;
        val          <= val + 4'd3;
      end else if (core_running) begin
        if (core_cnt == 1) begin
          core_running <= 1'b0;
          ctr_in       <= pend[6:3];
          done_pulse   <= 1'b1;
          sb.push_back(pend);
        end
        core_cnt <= core_cnt - 1;
      end
    end
  end

  // Head must match the oldest expected entry whenever valid, stalled or not.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0)
        check("sb_nonempty", sb.size(), 1);
      else begin
        check("head", 32'({out_data, out_sof, out_eol, out_eof}), 32'(sb[0]));
        if (out_ready)
          void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done_pulse) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int base;

    // Reset held with enable high, first run one cycle after release.
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      check("rst_run", 32'(run), 0);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_level", 32'(level), 0);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    check("idle_run", 32'(run), 0);
    step();
    @(negedge clk);
    check("first_run", 32'(run), 1);
    step();
    enable = 1'b0;

    // Single pixel: valid rises the cycle after completion.
    wait_done(20, ok);
    check("single_done", 32'(ok), 1);
    check("single_valid_pre", 32'(out_valid), 0);
    @(negedge clk);
    check("single_valid", 32'(out_valid), 1);
    check("single_level", 32'(level), 1);
    check("single_data", 32'(out_data), 32'hA);
    check("single_sof", 32'(out_sof), 1);
    check("single_eol", 32'(out_eol), 0);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Line/frame tags over a frame and a bit, then a finished resync.
    do_reset();
    out_ready = 1'b1;
    enable    = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_done(30, ok);
      check("tag_done", 32'(ok), 1);
    end
    step();
    enable   = 1'b0;
    finished = 1'b1;
    step();
    enable = 1'b1;
    wait_done(30, ok);
    check("resync_done", 32'(ok), 1);
    step();
    enable   = 1'b0;
    finished = 1'b0;
    repeat (4) step();
    check("tag_drained", sb.size(), 0);
    check("tag_runs", run_cnt, 12);

    // Backpressure: FIFO fills, issue stops, one pop allows exactly one more.
    do_reset();
    out_ready = 1'b0;
    enable    = 1'b1;
    base      = run_cnt;
    repeat (60) step();
    check("bp_runs", run_cnt - base, 4);
    check("bp_level", 32'(level), 4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_level_pop", 32'(level), 3);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (run_cnt - base == 5);
    end
    check("bp_fifth_run", 32'(ok), 1);
    enable = 1'b0;
    repeat (12) step();
    check("bp_level_full", 32'(level), 4);
    out_ready = 1'b1;
    repeat (8) step();
    out_ready = 1'b0;
    check("bp_drained", sb.size(), 0);
    check("bp_level_end", 32'(level), 0);

    // Simultaneous push and pop at level 2.
    do_reset();
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = (level == 3'd2);
    end
    check("sim_level2", 32'(ok), 1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = core_running && (core_cnt == 1);
    end
    check("sim_predone", 32'(ok), 1);
    step();
    out_ready = 1'b1;
    enable    = 1'b0;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("sim_level", 32'(level), 2);
    if (sb.size() > 0)
      check("sim_head", 32'(out_data), 32'(sb[0][6:3]));
    out_ready = 1'b1;
    repeat (4) step();
    out_ready = 1'b0;
    check("sim_drained", sb.size(), 0);

    // Enable dropped mid-pixel: pixel still lands, no further issue.
    do_reset();
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = run;
    end
    check("en_run", 32'(ok), 1);
    step();
    enable = 1'b0;
    base   = run_cnt;
    wait_done(20, ok);
    check("en_done", 32'(ok), 1);
    @(negedge clk);
    check("en_level", 32'(level), 1);
    repeat (15) step();
    check("en_no_run", run_cnt - base, 0);

    // Reset while busy: in-flight pixel and stored entry discarded.
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = core_running;
    end
    check("rb_busy", 32'(ok), 1);
    step();
    reset  = 1'b1;
    enable = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rb_level", 32'(level), 0);
    check("rb_valid", 32'(out_valid), 0);
    check("rb_data", 32'(out_data), 0);
    repeat (10) step();
    check("rb_no_push", 32'(level), 0);
    enable = 1'b1;
    step();
    @(negedge clk);
    check("rb_reissue", 32'(run), 1);
    step();
    enable    = 1'b0;
    out_ready = 1'b1;
    repeat (12) step();
    check("end_drained", sb.size(), 0);
    check("end_level", 32'(level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
